// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, one-deep memory pipeline, word buffer, redirect flush
`timescale 1ns/1ps
module inst_fetch_unit #(
  parameter int              ADDR_W     = 10,
  parameter int              DATA_W     = 16,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;

  logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign mem_addr   = redirect_valid ? redirect_addr : fetch_pc_q;

  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  assign pop  = inst_valid & inst_ready;
  // A response landing during a redirect belongs to the abandoned path.
  assign push = pend_q & ~redirect_valid;

  // Slots already spoken for: buffered words after this pop plus the word in flight.
  assign credit = (CNT_W+1)'(count_q) + (CNT_W+1)'(pend_q) - (CNT_W+1)'(pop);
  assign issue  = ~reset & (redirect_valid | (credit < DEPTH_C));

  always_comb begin
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    fetch_pc_d = fetch_pc_q;
    if (issue) begin
      pend_d     = 1'b1;
      pend_pc_d  = mem_addr;
      fetch_pc_d = mem_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      pend_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_pc_q[wr_ptr_q]   <= pend_pc_q;
      fifo_data_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RESET_PC(10'd0)
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  logic [DATA_W-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] next_pc;

  task automatic restart(input logic [ADDR_W-1:0] pc);
    exp_q.delete();
    next_pc = pc;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_t e;
      e.pc   = next_pc;
      e.data = 16'hA000 + 16'(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 10'd1;
    end
  endtask

  // Monitor: compares every handshake, enforces hold stability and post-flush bubbles
  int                pops = 0;
  int                blank = 0;
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_pc;
  logic [DATA_W-1:0] prev_data;
  exp_t              m_e;

  always @(negedge clk) begin
    if (blank > 0) begin
      chk("bubble_after_flush", int'(inst_valid), 0);
      blank--;
    end
    if (prev_hold) begin
      chk("hold_valid", int'(inst_valid), 1);
      chk("hold_pc", int'(inst_pc), int'(prev_pc));
      chk("hold_data", int'(inst_data), int'(prev_data));
    end
    if (!inst_valid)
      chk("idle_zero", int'({inst_pc, inst_data}), 0);
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("queue_underrun", 1, 0);
      end else begin
        m_e = exp_q.pop_front();
        chk("inst_pc", int'(inst_pc), int'(m_e.pc));
        chk("inst_data", int'(inst_data), int'(m_e.data));
        pops++;
      end
    end
    prev_hold = inst_valid && !inst_ready && !reset && !redirect_valid;
    prev_pc   = inst_pc;
    prev_data = inst_data;
    if (reset) blank = 2;
    else if (redirect_valid && blank < 1) blank = 1;
  end

  task automatic step();
    logic              r;
    logic              rv;
    logic [ADDR_W-1:0] ra;
    @(posedge clk);
    r  = reset;
    rv = redirect_valid;
    ra = redirect_addr;
    #1;
    if (r) restart(10'd0);
    else if (rv) restart(ra);
    top_up();
  endtask

  task automatic wait_head(input logic [ADDR_W-1:0] pc, input string name);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < 60) begin
      step();
      n++;
    end
    chk(name, int'(inst_valid && inst_pc == pc), 1);
  endtask

  task automatic pulse_redirect(input logic [ADDR_W-1:0] target, input string name);
    redirect_valid = 1'b1;
    redirect_addr  = target;
    #1;
    chk(name, int'(mem_addr), int'(target));
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int p0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
    restart(10'd0);
    top_up();
    step(); step();
    chk("reset_valid", int'(inst_valid), 0);
    chk("reset_pc", int'(inst_pc), 0);
    chk("reset_data", int'(inst_data), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);

    reset = 1'b0; inst_ready = 1'b1;
    lat = 0;
    while (!inst_valid && lat < 10) begin step(); lat++; end
    chk("first_valid_latency", lat, 2);
    chk("first_pc", int'(inst_pc), 0);
    chk("first_data", int'(inst_data), 16'hA000);
    for (int i = 0; i < 3; i++) begin
      chk("stream_no_gap", int'(inst_valid), 1);
      step();
    end

    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(inst_valid), 1);
      chk("bp_head_pc", int'(inst_pc), 3);
      chk("bp_head_data", int'(inst_data), 16'hA003);
      chk("bp_mem_addr_stall", int'(mem_addr), 5);
      step();
    end
    inst_ready = 1'b1;

    wait_head(10'd6, "reach_pc6");
    pulse_redirect(10'd200, "redirect_mem_addr");
    chk("redirect_flush_empty", int'(inst_valid), 0);
    step();
    chk("redirect_first_valid", int'(inst_valid), 1);
    chk("redirect_first_pc", int'(inst_pc), 200);
    chk("redirect_first_data", int'(inst_data), 16'hA0C8);
    step();
    chk("redirect_second_pc", int'(inst_pc), 201);

    inst_ready = 1'b0;
    repeat (4) step();
    chk("full_before_redirect", int'(inst_valid), 1);
    inst_ready = 1'b1;
    p0 = pops;
    pulse_redirect(10'd300, "redirect_full_mem_addr");
    chk("redirect_pop_once", pops - p0, 1);
    chk("redirect_full_flush", int'(inst_valid), 0);
    wait_head(10'd301, "redirect_full_target");

    pulse_redirect(10'd1022, "wrap_mem_addr");
    p0 = pops;
    wait_head(10'd1, "wrap_reach_1");
    chk("wrap_pop_count", pops - p0, 3);

    repeat (3) step();
    chk("pre_reset_valid", int'(inst_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_flush", int'(inst_valid), 0);
    lat = 0;
    while (!inst_valid && lat < 10) begin step(); lat++; end
    chk("reset_mid_latency", lat, 2);
    chk("reset_mid_pc", int'(inst_pc), 0);
    chk("reset_mid_data", int'(inst_data), 16'hA000);

    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = ADDR_W'($urandom);
      reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (6) step();
    chk("random_progress", int'(pops - p0 > 1000), 1);
    chk("drain_valid", int'(inst_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
